led_frame_buffer: RTL and testbench

- Double-buffered pixel memory feeding the LED matrix scan driver (the display's upstream stage).
- Holds two complete frames: a front frame, read by the scan driver through two read ports (top half and bottom half), and a back frame, written by the CPU/bus side.
- Frames swap only at the scan driver's end-of-frame pulse, so the panel never shows a torn image.
- A hardware clear engine fills the back frame with a constant value.

---
 rtl/led_frame_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_led_frame_buffer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : led_frame_buffer
// Description : Double-buffered pixel store for the LED matrix scan driver.
//               Two physical frames, each split into a top and bottom half.
//               The scan driver reads the front frame through two registered
//               read ports; the CPU writes the back frame. Frames exchange
//               roles only on the scan driver's end-of-frame pulse, and a
//               clear engine can flood the back frame with a constant.
// Revision    : 1.0 - initial release
// ============================================================================
module led_frame_buffer #(
  parameter int                HALF_DEPTH  = 2048,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  // CPU write side (back frame)
  input  logic                            wr_en,
  input  logic [$clog2(HALF_DEPTH):0]     wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic                            wr_ready,
  // Frame control
  input  logic                            swap_req,
  input  logic                            clear_req,
  output logic                            swap_pending,
  output logic                            swap_ack,
  output logic                            clear_busy,
  output logic                            front_sel,
  input  logic                            frame_done,
  // Scan driver read side (front frame)
  input  logic [$clog2(HALF_DEPTH)-1:0]   pixelAddress0,
  output logic [DATA_W-1:0]               pixel0,
  input  logic [$clog2(HALF_DEPTH)-1:0]   pixelAddress1,
  output logic [DATA_W-1:0]               pixel1
);

  // Pixel index width within a half, and full back-frame address width
  // (half select in the MSB).
  localparam int ADDR_W = $clog2(HALF_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  // Clear engine states
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [CNT_W-1:0]  clear_cnt;

  // Write-port arbitration
  logic              cpu_we;
  logic              mem_we;
  logic [CNT_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              back_sel;
  logic              top_we;
  logic              bot_we;
  logic [CNT_W-1:0]  wr_idx;
  logic [CNT_W-1:0]  rd_idx0;
  logic [CNT_W-1:0]  rd_idx1;

  // Swap control
  logic              swap_do;

  // One RAM per panel half; the MSB of the index picks the physical frame.
  // Each RAM has exactly one write port and one read port.
  logic [DATA_W-1:0] mem_top [0:2*HALF_DEPTH-1];
  logic [DATA_W-1:0] mem_bot [0:2*HALF_DEPTH-1];

  // --------------------------------------------------------------------------
  // Clear engine FSM
  // --------------------------------------------------------------------------

  // State register; reset aborts a clear in progress immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: start on request, finish after the last location is written.
  // Requests arriving mid-clear are ignored.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clear_cnt == CNT_LAST) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: busy for every cycle spent in CLEAR.
  always_comb begin
    clear_busy = 1'b0;
    case (state)
      ST_CLEAR: clear_busy = 1'b1;
      default:  clear_busy = 1'b0;
    endcase
  end

  // Clear address counter: held at zero while idle so every clear starts at
  // location 0; wraps back to 0 on the final write as the FSM returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clear_cnt <= '0;
    end else if (state == ST_IDLE) begin
      clear_cnt <= '0;
    end else begin
      clear_cnt <= clear_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------

  // The CPU is locked out while the clear engine owns the write port, so the
  // two sources never collide; dropped writes are retried by the writer.
  assign wr_ready = ~clear_busy;
  assign cpu_we   = wr_en & wr_ready;
  assign mem_we   = cpu_we | clear_busy;
  assign mem_addr = clear_busy ? clear_cnt   : wr_addr;
  assign mem_data = clear_busy ? CLEAR_VALUE : wr_data;

  // Writes target the frame that is back at this edge; a write landing on the
  // swap edge therefore lands in the frame that is about to become front.
  assign back_sel = ~front_sel;
  assign wr_idx   = {back_sel, mem_addr[ADDR_W-1:0]};
  assign top_we   = mem_we & ~mem_addr[ADDR_W];
  assign bot_we   = mem_we &  mem_addr[ADDR_W];

  // Top-half RAM write port (contents deliberately not reset).
  always_ff @(posedge clk) begin
    if (top_we) begin
      mem_top[wr_idx] <= mem_data;
    end
  end

  // Bottom-half RAM write port (contents deliberately not reset).
  always_ff @(posedge clk) begin
    if (bot_we) begin
      mem_bot[wr_idx] <= mem_data;
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------

  // Reads use the front selection in effect at the sampling edge.
  assign rd_idx0 = {front_sel, pixelAddress0};
  assign rd_idx1 = {front_sel, pixelAddress1};

  // Registered top-half pixel, one cycle of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel0 <= '0;
    end else begin
      pixel0 <= mem_top[rd_idx0];
    end
  end

  // Registered bottom-half pixel, one cycle of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel1 <= '0;
    end else begin
      pixel1 <= mem_bot[rd_idx1];
    end
  end

  // --------------------------------------------------------------------------
  // Frame swap
  // --------------------------------------------------------------------------

  // A swap happens on an end-of-frame pulse when one is requested (now or
  // earlier) and the clear engine is idle, so a clear never straddles a swap.
  assign swap_do = frame_done & (swap_pending | swap_req) & ~clear_busy;

  // Front selection, pending flag (merges repeated requests) and the
  // one-cycle acknowledge following the swap edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      swap_ack <= swap_do;
      if (swap_do) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_frame_buffer
// Description : Self-checking bench for led_frame_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_frame_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready;
  logic        swap_req = 1'b0;
  logic        clear_req = 1'b0;
  logic        swap_pending;
  logic        swap_ack;
  logic        clear_busy;
  logic        front_sel;
  logic        frame_done = 1'b0;
  logic [10:0] pixelAddress0 = '0;
  logic [7:0]  pixel0;
  logic [10:0] pixelAddress1 = '0;
  logic [7:0]  pixel1;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [8];

  led_frame_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .swap_req      (swap_req),
    .clear_req     (clear_req),
    .swap_pending  (swap_pending),
    .swap_ack      (swap_ack),
    .clear_busy    (clear_busy),
    .front_sel     (front_sel),
    .frame_done    (frame_done),
    .pixelAddress0 (pixelAddress0),
    .pixel0        (pixel0),
    .pixelAddress1 (pixelAddress1),
    .pixel1        (pixel1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write_px(input logic [11:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    logic [11:0] a;

    vecs[0] = '{addr: 12'h000, data: 8'h11, exp: 8'h3C};  // overwritten by entry 5
    vecs[1] = '{addr: 12'h7FF, data: 8'h22, exp: 8'h22};
    vecs[2] = '{addr: 12'h800, data: 8'h33, exp: 8'h33};
    vecs[3] = '{addr: 12'hFFF, data: 8'h44, exp: 8'h44};
    vecs[4] = '{addr: 12'h123, data: 8'h3F, exp: 8'h3F};
    vecs[5] = '{addr: 12'h000, data: 8'h3C, exp: 8'h3C};
    vecs[6] = '{addr: 12'h923, data: 8'h05, exp: 8'h05};
    vecs[7] = '{addr: 12'h400, data: 8'h2B, exp: 8'h2B};

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_front_sel", front_sel, 0);
    check("rst_swap_pending", swap_pending, 0);
    check("rst_swap_ack", swap_ack, 0);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_pixel0", pixel0, 0);
    check("rst_pixel1", pixel1, 0);
    rst = 1'b1;
    tick();

    // ---------------- basic write / swap / read ----------------
    write_px(12'h005, 8'h15);
    write_px(12'h805, 8'h2A);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("t1_pending", swap_pending, 1);
    check("t1_front_before", front_sel, 0);
    pulse_frame_done();
    check("t1_swap_ack", swap_ack, 1);
    check("t1_front_sel", front_sel, 1);
    check("t1_pending_clr", swap_pending, 0);
    pixelAddress0 = 11'h005;
    pixelAddress1 = 11'h005;
    tick();
    check("t1_swap_ack_drop", swap_ack, 0);
    check("t1_pixel0", pixel0, 8'h15);
    check("t1_pixel1", pixel1, 8'h2A);

    // ---------------- table-driven writes into frame 0, then readback ----------------
    for (int i = 0; i < 8; i++) begin
      write_px(vecs[i].addr, vecs[i].data);
    end
    swap_req   = 1'b1;
    frame_done = 1'b1;
    tick();
    swap_req   = 1'b0;
    frame_done = 1'b0;
    check("tbl_front_sel", front_sel, 0);
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].addr;
      pixelAddress0 = a[10:0];
      pixelAddress1 = a[10:0];
      tick();
      if (a[11]) check($sformatf("tbl_rd1_%0d", i), pixel1, vecs[i].exp);
      else       check($sformatf("tbl_rd0_%0d", i), pixel0, vecs[i].exp);
    end

    // ---------------- no swap without frame_done ----------------
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (100) tick();
    check("hold_pending", swap_pending, 1);
    check("hold_front", front_sel, 0);
    pulse_frame_done();
    check("hold_swap_front", front_sel, 1);
    check("hold_swap_pending", swap_pending, 0);
    check("hold_swap_ack", swap_ack, 1);

    // ---------------- same-edge swap ----------------
    swap_req   = 1'b1;
    frame_done = 1'b1;
    tick();
    swap_req   = 1'b0;
    frame_done = 1'b0;
    check("same_front", front_sel, 0);
    check("same_ack", swap_ack, 1);
    check("same_pending", swap_pending, 0);
    tick();
    check("same_pending2", swap_pending, 0);
    check("same_ack2", swap_ack, 0);

    // ---------------- clear of back frame (frame 1) ----------------
    pixelAddress0 = 11'h7FF;   // front frame 0 holds 8'h22 here
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (clear_busy && n < 5000) begin
      if (n == 10) begin
        check("clr_wr_ready", wr_ready, 0);
        check("clr_front_intact", pixel0, 8'h22);
      end
      if (n == 20) begin
        wr_en   = 1'b1;
        wr_addr = 12'h005;
        wr_data = 8'hEE;
      end
      if (n == 30) wr_en = 1'b0;
      n++;
      tick();
    end
    wr_en = 1'b0;
    check("clr_cycles", n, 4096);
    check("clr_wr_ready_after", wr_ready, 1);
    check("clr_front_after", pixel0, 8'h22);
    swap_req   = 1'b1;
    frame_done = 1'b1;
    tick();
    swap_req   = 1'b0;
    frame_done = 1'b0;
    check("clr_swap_front", front_sel, 1);
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      pixelAddress0 = 11'(i);
      pixelAddress1 = 11'(i);
      tick();
      if (pixel0 !== 8'h00 || pixel1 !== 8'h00) bad++;
    end
    check("clr_sweep_nonzero", bad, 0);

    // ---------------- swap blocked by clear ----------------
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (98) tick();
    pulse_frame_done();
    check("blk_front", front_sel, 1);
    check("blk_pending", swap_pending, 1);
    check("blk_ack", swap_ack, 0);
    n = 0;
    while (clear_busy && n < 5000) begin
      n++;
      tick();
    end
    check("blk_clear_ended", clear_busy, 0);
    check("blk_front_after", front_sel, 1);
    check("blk_pending_after", swap_pending, 1);
    pulse_frame_done();
    check("blk_swap_front", front_sel, 0);
    check("blk_swap_ack", swap_ack, 1);
    check("blk_swap_pending", swap_pending, 0);

    // ---------------- reset mid-clear ----------------
    swap_req   = 1'b1;
    frame_done = 1'b1;
    tick();
    swap_req   = 1'b0;
    frame_done = 1'b0;
    check("mid_front_pre", front_sel, 1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (1998) tick();
    check("mid_busy_pre", clear_busy, 1);
    check("mid_pending_pre", swap_pending, 1);
    rst = 1'b0;
    #1;
    check("mid_front_sel", front_sel, 0);
    check("mid_pending", swap_pending, 0);
    check("mid_ack", swap_ack, 0);
    check("mid_busy", clear_busy, 0);
    check("mid_wr_ready", wr_ready, 1);
    check("mid_pixel0", pixel0, 0);
    check("mid_pixel1", pixel1, 0);
    tick();
    rst = 1'b1;
    tick();
    write_px(12'h010, 8'h5A);
    write_px(12'h810, 8'hA5);
    swap_req   = 1'b1;
    frame_done = 1'b1;
    tick();
    swap_req   = 1'b0;
    frame_done = 1'b0;
    check("post_front", front_sel, 1);
    pixelAddress0 = 11'h010;
    pixelAddress1 = 11'h010;
    tick();
    check("post_pixel0", pixel0, 8'h5A);
    check("post_pixel1", pixel1, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
